// File: rtl/sfp_ctrl_pkg.sv
// Shared definitions for the SFP+ port management sequencer.
//   STATE_W / RETRY_W : widths of the per-port state and retry counter fields
//   port_state_t      : per-port sequencer state, encoding visible on port_state
//   retry_sat_inc     : retry counter increment that saturates at all-ones
package sfp_ctrl_pkg;

   localparam int STATE_W = 3;
   localparam int RETRY_W = 2;

   typedef enum logic [STATE_W-1:0] {
      ST_DISABLED = 3'd0,
      ST_ABSENT   = 3'd1,
      ST_SETTLE   = 3'd2,
      ST_ENABLED  = 3'd3,
      ST_UP       = 3'd4,
      ST_FAULT    = 3'd5,
      ST_LOCKOUT  = 3'd6
   } port_state_t;

   function automatic logic [RETRY_W-1:0] retry_sat_inc(input logic [RETRY_W-1:0] cnt);
      return (&cnt) ? cnt : cnt + 1'b1;
   endfunction

endpackage

// File: rtl/sfp_port_ctrl_if.sv
// Cage-side pad bundle for the SFP+ front end.
//   sfp_mod_detect : 1 = module present (async pad)
//   sfp_los        : 1 = loss of signal (async pad)
//   sfp_tx_fault   : 1 = transmitter fault (async pad)
//   sfp_tx_disable : 1 = laser off
//   sfp_rs         : RS[1:0] per cage
//   i2c_mux_reset  : active-low PCA9548 reset
// master = the port controller, slave = the cage/pad side.
interface sfp_port_ctrl_if #(
   parameter int N_PORTS = 4
);

   logic [N_PORTS-1:0]   sfp_mod_detect;
   logic [N_PORTS-1:0]   sfp_los;
   logic [N_PORTS-1:0]   sfp_tx_fault;
   logic [N_PORTS-1:0]   sfp_tx_disable;
   logic [2*N_PORTS-1:0] sfp_rs;
   logic                 i2c_mux_reset;

   modport master (
      input  sfp_mod_detect, sfp_los, sfp_tx_fault,
      output sfp_tx_disable, sfp_rs, i2c_mux_reset
   );

   modport slave (
      output sfp_mod_detect, sfp_los, sfp_tx_fault,
      input  sfp_tx_disable, sfp_rs, i2c_mux_reset
   );

endinterface

// File: rtl/sfp_debounce.sv
// Synchronizer plus tick-based debouncer for one SFP status pad.
//   clk, rst_n : system clock, async active-low reset
//   i_tick     : shared 1-cycle timebase pulse
//   i_din      : raw asynchronous pad
//   o_dout     : accepted value, INIT out of reset
// The accepted value flips on the tick that completes DEBOUNCE_TICKS
// consecutive ticks of disagreement; any agreement reloads the counter.
module sfp_debounce
   import sfp_ctrl_pkg::*;
#(
   parameter logic INIT           = 1'b0,
   parameter int   TMR_W          = 20,
   parameter int   DEBOUNCE_TICKS = 1000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_tick,
   input  logic i_din,
   output logic o_dout
);

   localparam logic [TMR_W-1:0] CNT_LOAD = TMR_W'(DEBOUNCE_TICKS - 1);

   logic             r_meta;
   logic             r_sync;
   logic             r_dout;
   logic [TMR_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= INIT;
         r_sync <= INIT;
         r_dout <= INIT;
         r_cnt  <= CNT_LOAD;
      end else begin
         r_meta <= i_din;
         r_sync <= r_meta;
         if (r_sync == r_dout) begin
            r_cnt <= CNT_LOAD;
         end else if (i_tick) begin
            if (r_cnt == '0) begin
               r_dout <= r_sync;
               r_cnt  <= CNT_LOAD;
            end else begin
               r_cnt <= r_cnt - 1'b1;
            end
         end
      end
   end

   assign o_dout = r_dout;

endmodule

// File: rtl/sfp_port_ctrl.sv
// Per-port SFP+ module management sequencer.
//   clk, rst_n   : 125 MHz system clock, async active-low reset
//   port_enable  : software enable per port
//   rate_sel     : requested RS[1:0] per port
//   fault_clear  : 1-cycle pulse, releases LOCKOUT
//   sfp_if       : cage pads (detect, los, tx_fault in; tx_disable, rs, mux reset out)
//   link_up      : port is in UP
//   port_state   : registered state code per port
//   retry_cnt    : faults since last clear, saturating
//
// state    | meaning
// ---------+-----------------------------------------------------
// DISABLED | software has the port off, laser off
// ABSENT   | enabled, waiting for a debounced module-present
// SETTLE   | module inserted, waiting INSERT_WAIT_TICKS
// ENABLED  | laser on, waiting for LOS to clear
// UP       | laser on, LOS clear
// FAULT    | tx_fault seen; hold laser off for HOLDOFF_TICKS
// LOCKOUT  | too many faults, laser off until fault_clear
module sfp_port_ctrl
   import sfp_ctrl_pkg::*;
#(
   parameter int N_PORTS           = 4,
   parameter int TICK_DIV          = 125,
   parameter int TMR_W             = 20,
   parameter int DEBOUNCE_TICKS    = 1000,
   parameter int INSERT_WAIT_TICKS = 300000,
   parameter int HOLDOFF_TICKS     = 10000,
   parameter int MAX_RETRY         = 3,
   parameter int MUX_RST_TICKS     = 10
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [N_PORTS-1:0]         port_enable,
   input  logic [2*N_PORTS-1:0]       rate_sel,
   input  logic [N_PORTS-1:0]         fault_clear,
   sfp_port_ctrl_if.master            sfp_if,
   output logic [N_PORTS-1:0]         link_up,
   output logic [STATE_W*N_PORTS-1:0] port_state,
   output logic [RETRY_W*N_PORTS-1:0] retry_cnt
);

   localparam int               PRESC_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PRESC_W-1:0] PRESC_LOAD = PRESC_W'(TICK_DIV - 1);
   localparam logic [TMR_W-1:0] INSERT_LOAD  = TMR_W'(INSERT_WAIT_TICKS);
   localparam logic [TMR_W-1:0] HOLDOFF_LOAD = TMR_W'(HOLDOFF_TICKS);
   localparam logic [TMR_W-1:0] MUX_LOAD     = TMR_W'(MUX_RST_TICKS);
   // The counter saturates at 3, so a larger limit would never trip.
   localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'((MAX_RETRY > 3) ? 3 : MAX_RETRY);

   logic [PRESC_W-1:0] r_presc;
   logic               w_tick;
   logic [TMR_W-1:0]   r_mux_tmr;
   logic               r_mux_rst_n;
   logic [N_PORTS-1:0] r_flt_meta;
   logic [N_PORTS-1:0] r_flt_sync;
   logic [N_PORTS-1:0] w_tx_dis;
   logic [2*N_PORTS-1:0] w_rs;

   assign w_tick = (r_presc == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_presc <= PRESC_LOAD;
      end else if (w_tick) begin
         r_presc <= PRESC_LOAD;
      end else begin
         r_presc <= r_presc - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mux_tmr   <= MUX_LOAD;
         r_mux_rst_n <= 1'b0;
      end else begin
         if (w_tick && (r_mux_tmr != '0)) begin
            r_mux_tmr <= r_mux_tmr - 1'b1;
         end
         r_mux_rst_n <= (r_mux_tmr == '0);
      end
   end

   // tx_fault is acted on immediately, so it gets a synchronizer but no debounce.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_flt_meta <= '0;
         r_flt_sync <= '0;
      end else begin
         r_flt_meta <= sfp_if.sfp_tx_fault;
         r_flt_sync <= r_flt_meta;
      end
   end

   for (genvar p = 0; p < N_PORTS; p++) begin : g_port
      logic               w_present;
      logic               w_los;
      logic               w_flt;
      logic               w_en;
      logic               w_clr;
      port_state_t        r_state;
      logic [TMR_W-1:0]   r_tmr;
      logic [RETRY_W-1:0] r_retry;
      logic               r_tx_dis;
      logic               r_link;
      logic [1:0]         r_rs;
      logic [STATE_W-1:0] r_pstate;

      sfp_debounce #(
         .INIT           (1'b0),
         .TMR_W          (TMR_W),
         .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
      ) u_det (
         .clk    (clk),
         .rst_n  (rst_n),
         .i_tick (w_tick),
         .i_din  (sfp_if.sfp_mod_detect[p]),
         .o_dout (w_present)
      );

      sfp_debounce #(
         .INIT           (1'b1),
         .TMR_W          (TMR_W),
         .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
      ) u_los (
         .clk    (clk),
         .rst_n  (rst_n),
         .i_tick (w_tick),
         .i_din  (sfp_if.sfp_los[p]),
         .o_dout (w_los)
      );

      assign w_flt = r_flt_sync[p];
      assign w_en  = port_enable[p];
      assign w_clr = fault_clear[p];

      // Outputs follow r_state one cycle later; async reset forces laser off at once.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_state  <= ST_DISABLED;
            r_tmr    <= '0;
            r_retry  <= '0;
            r_tx_dis <= 1'b1;
            r_link   <= 1'b0;
            r_rs     <= 2'b00;
            r_pstate <= ST_DISABLED;
         end else begin
            r_tx_dis <= !((r_state == ST_ENABLED) || (r_state == ST_UP));
            r_link   <= (r_state == ST_UP);
            r_pstate <= r_state;
            r_rs     <= w_en ? rate_sel[2*p +: 2] : 2'b00;

            if (!w_en) begin
               r_state <= ST_DISABLED;
               r_retry <= '0;
            end else if (!w_present && (r_state != ST_DISABLED)) begin
               r_state <= ST_ABSENT;
               r_retry <= '0;
            end else begin
               case (r_state)
                  ST_DISABLED: begin
                     r_state <= ST_ABSENT;
                     r_retry <= '0;
                  end
                  ST_ABSENT: begin
                     if (w_present) begin
                        r_state <= ST_SETTLE;
                        r_tmr   <= INSERT_LOAD;
                     end
                  end
                  ST_SETTLE: begin
                     if (r_tmr == '0) begin
                        r_state <= ST_ENABLED;
                     end else if (w_tick) begin
                        r_tmr <= r_tmr - 1'b1;
                     end
                  end
                  ST_ENABLED, ST_UP: begin
                     if (w_flt) begin
                        r_state <= ST_FAULT;
                        r_retry <= retry_sat_inc(r_retry);
                        r_tmr   <= HOLDOFF_LOAD;
                     end else if ((r_state == ST_ENABLED) && !w_los) begin
                        r_state <= ST_UP;
                     end else if ((r_state == ST_UP) && w_los) begin
                        r_state <= ST_ENABLED;
                     end
                  end
                  ST_FAULT: begin
                     // r_retry already holds the post-increment count here.
                     if (r_retry >= RETRY_LIMIT) begin
                        r_state <= ST_LOCKOUT;
                     end else if (r_tmr == '0) begin
                        r_state <= ST_ENABLED;
                     end else if (w_tick) begin
                        r_tmr <= r_tmr - 1'b1;
                     end
                  end
                  ST_LOCKOUT: begin
                     if (w_clr) begin
                        r_state <= ST_ABSENT;
                        r_retry <= '0;
                     end
                  end
                  default: begin
                     r_state <= ST_DISABLED;
                  end
               endcase
            end
         end
      end

      assign w_tx_dis[p]                         = r_tx_dis;
      assign w_rs[2*p +: 2]                      = r_rs;
      assign link_up[p]                          = r_link;
      assign port_state[STATE_W*p +: STATE_W]    = r_pstate;
      assign retry_cnt[RETRY_W*p +: RETRY_W]     = r_retry;
   end

   assign sfp_if.sfp_tx_disable = w_tx_dis;
   assign sfp_if.sfp_rs         = w_rs;
   assign sfp_if.i2c_mux_reset  = r_mux_rst_n;

endmodule

// File: doc/sfp_port_ctrl.md
Name: sfp_port_ctrl

Overview:
- Per-port SFP+ module management sequencer for the four-port 10G front end.
- Debounces module-detect and LOS, and sequences sfp_N_tx_disable through insertion settle, enable, link-up, fault hold-off/retry and lockout.
- Drives rate-select pins and the I2C mux reset after power-up.
- Sits in the fpga top beside the 125 MHz MMCM domain, feeding pad-level SFP control pins and reporting per-port status to the NTP server core.

Parameters:
- N_PORTS, 4, number of SFP cages.
- TICK_DIV, 125, clk cycles per timer tick (1 us at 125 MHz).
- TMR_W, 20, timer/counter width in bits.
- DEBOUNCE_TICKS, 1000, ticks an input must stay stable before it is accepted.
- INSERT_WAIT_TICKS, 300000, settle time after insertion (SFF t_init).
- HOLDOFF_TICKS, 10000, tx_disable hold after a tx_fault.
- MAX_RETRY, 3, faults tolerated before lockout.
- MUX_RST_TICKS, 10, i2c_mux_reset assertion length after reset.

Ports:
- clk  in  1  125 MHz system clock
- rst_n  in  1  reset; asynchronous assert, active-low
- port_enable  in  N_PORTS  software enable per port
- rate_sel  in  2*N_PORTS  requested RS[1:0] per port
- fault_clear  in  N_PORTS  one-cycle pulse; releases LOCKOUT
- sfp_mod_detect  in  N_PORTS  1 = module present (asynchronous pad)
- sfp_los  in  N_PORTS  1 = loss of signal (asynchronous pad)
- sfp_tx_fault  in  N_PORTS  1 = transmitter fault (asynchronous pad)
- sfp_tx_disable  out  N_PORTS  1 = laser off
- sfp_rs  out  2*N_PORTS  rate select to cage
- i2c_mux_reset  out  1  active-low PCA9548 reset
- link_up  out  N_PORTS  port state == UP
- port_state  out  3*N_PORTS  encoded FSM state per port
- retry_cnt  out  2*N_PORTS  faults since last clear, saturating at 3

Behaviour:
- Reset values:
  - sfp_tx_disable all 1; sfp_rs 0; i2c_mux_reset 0; link_up 0.
  - State DISABLED; retry_cnt 0.
  - Debounced present = 0, debounced los = 1.
- Inputs:
  - All pad inputs pass through a 2-FF synchronizer.
  - mod_detect and los are then debounced: the accepted value changes on the tick at which the raw synchronized value has differed for DEBOUNCE_TICKS consecutive ticks. Any return to the old value restarts the count.
  - tx_fault is synchronized only, with no debounce.
- Tick: a free-running prescaler pulses tick for 1 cycle every TICK_DIV clks. It is shared by all timers.
- i2c_mux_reset: held 0 until MUX_RST_TICKS ticks after rst_n deasserts, then 1 until the next reset.
- State encoding: DISABLED=0, ABSENT=1, SETTLE=2, ENABLED=3, UP=4, FAULT=5, LOCKOUT=6.
- Transition priority, highest first:
  - port_enable=0 goes to DISABLED.
  - Debounced present=0 goes to ABSENT, except from DISABLED.
  - Per-state rules below.
- Per-state rules:
  - DISABLED: enable=1 -> ABSENT.
  - ABSENT: present=1 -> SETTLE; load timer with INSERT_WAIT_TICKS.
  - SETTLE: timer reaches 0 on a tick -> ENABLED.
  - ENABLED: tx_fault=1 -> FAULT; else los=0 -> UP.
  - UP: tx_fault=1 -> FAULT; else los=1 -> ENABLED.
  - FAULT, on entry: retry_cnt increments, saturating at 3. If the new count >= MAX_RETRY, go next cycle to LOCKOUT. Otherwise load HOLDOFF_TICKS; timer reaching 0 -> ENABLED.
  - LOCKOUT: fault_clear -> ABSENT.
- retry_cnt is cleared on entry to DISABLED or ABSENT.
- Timer: decrements only on tick. A transition is taken in the cycle after the tick that brings it to 0. Re-entering a timed state reloads the timer.
- Output rules:
  - sfp_tx_disable = 0 only in ENABLED and UP; registered, valid the cycle after the state change.
  - sfp_rs = registered rate_sel for enabled ports, else 00.
  - link_up and port_state are registered from state.
- Simultaneous events:
  - fault_clear while present drops: ABSENT either way.
  - tx_fault and los=0 together in ENABLED: FAULT wins.
  - fault_clear in any state other than LOCKOUT is ignored.
- Reset mid-operation: all ports return to DISABLED with tx_disable=1 immediately (asynchronous).

Decomposition:
- Package sfp_ctrl_pkg holds:
  - the state encoding constants;
  - STATE_W=3;
  - RETRY_W=2.
- Sub-module sfp_debounce: one per input per port, containing the synchronizer, stability counter and accepted output, with init-value parameter.

Test Plan:
All scenarios use TICK_DIV=4, DEBOUNCE_TICKS=3, INSERT_WAIT_TICKS=10, HOLDOFF_TICKS=5, MAX_RETRY=2, MUX_RST_TICKS=2.
1. Release rst_n -> i2c_mux_reset is 0 for 8 clks (+/- prescaler phase), then 1. All tx_disable=1, port_state=0.
2. Port 0: enable, mod_detect=1, los=0 -> ABSENT, SETTLE, ENABLED after ~10 ticks. tx_disable[0]=0, then UP with link_up[0]=1. Other ports stay DISABLED.
3. Port 1 in UP: pulse tx_fault for 1 clk -> FAULT with tx_disable=1 and retry_cnt=1. After 5 ticks -> ENABLED, then UP.
4. Port 1: second fault -> LOCKOUT with tx_disable=1. fault_clear -> ABSENT with retry_cnt=0, then the full settle sequence.
5. Port 2 in UP: mod_detect glitch of 2 ticks -> no state change. Low for 3 ticks -> ABSENT, tx_disable=1.
6. Port 3 in UP, rate_sel=2'b11: deassert port_enable -> DISABLED next cycle, sfp_rs[7:6]=00. Assert rst_n=0 mid-SETTLE on any port -> tx_disable=1 immediately.
